// File: rtl/tlv_pkg.sv
// rtl/tlv_pkg.sv - shared widths, sample record and saturation helpers for the TLV493 sample filter
package tlv_pkg;
  localparam int RAW_W  = 12;
  localparam int AXIS_W = 16;
  localparam int FRM_W  = 2;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [RAW_W-1:0] x;
    logic [RAW_W-1:0] y;
    logic [RAW_W-1:0] z;
    logic [RAW_W-1:0] temp;
    logic [FRM_W-1:0] frm;
  } sample_t;

  // Adds two 17-bit signed operands and clamps the result into the signed 16-bit range.
  function automatic logic [AXIS_W-1:0] sat_add(input logic signed [AXIS_W:0] a,
                                                input logic signed [AXIS_W:0] b);
    logic signed [AXIS_W+1:0] sum;
    sum = {a[AXIS_W], a} + {b[AXIS_W], b};
    if (sum[AXIS_W+1:AXIS_W-1] == 3'b000 || sum[AXIS_W+1:AXIS_W-1] == 3'b111)
      return sum[AXIS_W-1:0];
    else if (sum[AXIS_W+1])
      return {1'b1, {(AXIS_W-1){1'b0}}};
    else
      return {1'b0, {(AXIS_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/tlv_sample_filter_axis.sv
// rtl/tlv_sample_filter_axis.sv - one axis: saturating offset subtract, then box-car accumulate and shift
module tlv_axis_avg
  import tlv_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              add,
  input  logic              last,
  input  logic [RAW_W-1:0]  raw,
  input  logic [AXIS_W-1:0] offset,
  output logic [AXIS_W-1:0] result
);
  localparam int ACC_W = AXIS_W + AVG_LOG2;

  logic signed [AXIS_W-1:0] corr;
  logic signed [AXIS_W:0]   raw_ext;
  logic signed [AXIS_W:0]   neg_off;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;

  assign raw_ext = {{(AXIS_W+1-RAW_W){raw[RAW_W-1]}}, raw};
  // 17-bit negation so that -(-32768) is representable before saturation.
  assign neg_off = -$signed({offset[AXIS_W-1], offset});
  assign sum     = acc + ACC_W'(corr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corr   <= '0;
      acc    <= '0;
      result <= '0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      if (load)
        corr <= sat_add(raw_ext, neg_off);
      if (add) begin
        if (last) begin
          result <= AXIS_W'(sum >>> AVG_LOG2);
          acc    <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end
endmodule

// File: rtl/tlv_sample_filter.sv
// rtl/tlv_sample_filter.sv - frame accept/stale filter, calibration and decimating average for one TLV493 sensor
module tlv_sample_filter
  import tlv_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int STALE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [RAW_W-1:0]  in_x,
  input  logic [RAW_W-1:0]  in_y,
  input  logic [RAW_W-1:0]  in_z,
  input  logic [RAW_W-1:0]  in_temp,
  input  logic [FRM_W-1:0]  in_frm,
  input  logic              in_ack_error,
  input  logic [AXIS_W-1:0] offset_x,
  input  logic [AXIS_W-1:0] offset_y,
  input  logic [AXIS_W-1:0] offset_z,
  output logic              out_valid,
  output logic [AXIS_W-1:0] out_x,
  output logic [AXIS_W-1:0] out_y,
  output logic [AXIS_W-1:0] out_z,
  output logic [RAW_W-1:0]  out_temp,
  output logic              stale_flag,
  output logic [15:0]       drop_count,
  output logic [15:0]       err_count
);
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam int TACC_W = RAW_W + AVG_LOG2;
  localparam logic [7:0] STALE_LIM = 8'(STALE_LIMIT);

  sample_t           smp;
  logic              have_last;
  logic [FRM_W-1:0]  last_frm;
  logic [7:0]        stale_run;
  logic [7:0]        stale_next;
  logic              is_err;
  logic              is_stale;
  logic              accept;
  logic              s1_valid;
  logic [RAW_W-1:0]  s1_temp;
  logic [CNT_W-1:0]  acc_cnt;
  logic              last;
  logic [TACC_W-1:0] temp_acc;
  logic [TACC_W-1:0] temp_sum;

  assign smp        = '{x: in_x, y: in_y, z: in_z, temp: in_temp, frm: in_frm};
  assign is_err     = in_valid && in_ack_error;
  assign is_stale   = in_valid && !in_ack_error && have_last && (smp.frm == last_frm);
  assign accept     = in_valid && !in_ack_error && !is_stale;
  assign stale_next = (stale_run == 8'hFF) ? stale_run : stale_run + 8'd1;
  assign last       = (acc_cnt == CNT_LAST);
  assign temp_sum   = temp_acc + TACC_W'(s1_temp);

  tlv_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_axis_x (
    .clock(clock), .reset(reset), .clear(clear), .load(accept), .add(s1_valid), .last(last),
    .raw(smp.x), .offset(offset_x), .result(out_x)
  );
  tlv_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_axis_y (
    .clock(clock), .reset(reset), .clear(clear), .load(accept), .add(s1_valid), .last(last),
    .raw(smp.y), .offset(offset_y), .result(out_y)
  );
  tlv_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_axis_z (
    .clock(clock), .reset(reset), .clear(clear), .load(accept), .add(s1_valid), .last(last),
    .raw(smp.z), .offset(offset_z), .result(out_z)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      have_last  <= 1'b0;
      last_frm   <= '0;
      stale_run  <= '0;
      stale_flag <= 1'b0;
      drop_count <= '0;
      err_count  <= '0;
      s1_valid   <= 1'b0;
      s1_temp    <= '0;
      acc_cnt    <= '0;
      temp_acc   <= '0;
      out_temp   <= '0;
      out_valid  <= 1'b0;
    end else if (clear) begin
      // Output data registers deliberately keep their last block.
      have_last  <= 1'b0;
      last_frm   <= '0;
      stale_run  <= '0;
      stale_flag <= 1'b0;
      drop_count <= '0;
      err_count  <= '0;
      s1_valid   <= 1'b0;
      acc_cnt    <= '0;
      temp_acc   <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= s1_valid && last;
      s1_valid  <= accept;
      if (accept) begin
        s1_temp    <= smp.temp;
        last_frm   <= smp.frm;
        have_last  <= 1'b1;
        stale_run  <= '0;
        stale_flag <= 1'b0;
      end
      if (is_err) begin
        err_count  <= (err_count == CNT_MAX) ? err_count : err_count + 16'd1;
        drop_count <= (drop_count == CNT_MAX) ? drop_count : drop_count + 16'd1;
      end
      if (is_stale) begin
        drop_count <= (drop_count == CNT_MAX) ? drop_count : drop_count + 16'd1;
        stale_run  <= stale_next;
        if (stale_next == STALE_LIM)
          stale_flag <= 1'b1;
      end
      if (s1_valid) begin
        if (last) begin
          out_temp <= RAW_W'(temp_sum >> AVG_LOG2);
          temp_acc <= '0;
          acc_cnt  <= '0;
        end else begin
          temp_acc <= temp_sum;
          acc_cnt  <= acc_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_tlv_sample_filter.sv
// tb/tb_tlv_sample_filter.sv - directed vector bench for tlv_sample_filter (AVG_LOG2=2 plus an AVG_LOG2=0 twin)
module tb_tlv_sample_filter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_x = '0, in_y = '0, in_z = '0, in_temp = '0;
  logic [1:0]  in_frm = '0;
  logic        in_ack_error = 1'b0;
  logic [15:0] offset_x = '0, offset_y = '0, offset_z = '0;

  logic        out_valid, stale_flag;
  logic [15:0] out_x, out_y, out_z, drop_count, err_count;
  logic [11:0] out_temp;
  logic        ov0, stale0;
  logic [15:0] x0, y0, z0, drop0, err0;
  logic [11:0] t0;

  int errors = 0;
  int checks = 0;

  tlv_sample_filter #(.AVG_LOG2(2), .STALE_LIMIT(3)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_temp(in_temp), .in_frm(in_frm),
    .in_ack_error(in_ack_error), .offset_x(offset_x), .offset_y(offset_y), .offset_z(offset_z),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_temp(out_temp),
    .stale_flag(stale_flag), .drop_count(drop_count), .err_count(err_count)
  );

  tlv_sample_filter #(.AVG_LOG2(0), .STALE_LIMIT(3)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_temp(in_temp), .in_frm(in_frm),
    .in_ack_error(in_ack_error), .offset_x(offset_x), .offset_y(offset_y), .offset_z(offset_z),
    .out_valid(ov0), .out_x(x0), .out_y(y0), .out_z(z0), .out_temp(t0),
    .stale_flag(stale0), .drop_count(drop0), .err_count(err0)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x, y, z, t, frm, err, offx;
    int acc, ov, ex, ey, ez, et, e0x, drop, errc, stale;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int x, y, z, t, frm, err, offx, acc, ov, ex, ey, ez, et, e0x,
                         drop, errc, stale);
    vec_t v;
    v = '{x, y, z, t, frm, err, offx, acc, ov, ex, ey, ez, et, e0x, drop, errc, stale};
    vecs.push_back(v);
  endtask

  task automatic strobe(input int x, y, z, t, frm, err, offx);
    @(negedge clock);
    in_valid = 1'b1;
    in_x = 12'(x); in_y = 12'(y); in_z = 12'(z); in_temp = 12'(t);
    in_frm = 2'(frm); in_ack_error = err[0]; offset_x = 16'(offx);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    int npulse, first_p, second_p, xa, xb;

    //      x      y   z  t  frm err offx    acc ov  ex      ey ez et  e0x     drop errc stale
    add_vec(100,   -5, 0, 10, 0, 0, 0,       1, 0, 0,      0, 0, 0,  100,    0, 0, 0);
    add_vec(102,   -6, 1, 11, 1, 0, 0,       1, 0, 0,      0, 0, 0,  102,    0, 0, 0);
    add_vec(104,   -7, 2, 12, 2, 0, 0,       1, 0, 0,      0, 0, 0,  104,    0, 0, 0);
    add_vec(106,   -8, 3, 13, 3, 0, 0,       1, 1, 103,   -7, 1, 11, 106,    0, 0, 0);
    add_vec(0,      0, 0, 0,  0, 1, 0,       0, 0, 0,      0, 0, 0,  0,      1, 1, 0);
    add_vec(8,      0, 0, 0,  0, 0, 0,       1, 0, 0,      0, 0, 0,  8,      1, 1, 0);
    add_vec(0,      0, 0, 0,  1, 1, 0,       0, 0, 0,      0, 0, 0,  0,      2, 2, 0);
    add_vec(8,      0, 0, 0,  1, 0, 0,       1, 0, 0,      0, 0, 0,  8,      2, 2, 0);
    add_vec(8,      0, 0, 0,  2, 0, 0,       1, 0, 0,      0, 0, 0,  8,      2, 2, 0);
    add_vec(-8,     0, 0, 0,  3, 0, 0,       1, 1, 4,      0, 0, 0,  -8,     2, 2, 0);
    add_vec(1,      0, 0, 0,  1, 0, 0,       1, 0, 0,      0, 0, 0,  1,      2, 2, 0);
    add_vec(1,      0, 0, 0,  1, 0, 0,       0, 0, 0,      0, 0, 0,  0,      3, 2, 0);
    add_vec(1,      0, 0, 0,  1, 0, 0,       0, 0, 0,      0, 0, 0,  0,      4, 2, 0);
    add_vec(1,      0, 0, 0,  1, 0, 0,       0, 0, 0,      0, 0, 0,  0,      5, 2, 1);
    add_vec(2,      0, 0, 0,  2, 0, 0,       1, 0, 0,      0, 0, 0,  2,      5, 2, 0);
    add_vec(3,      0, 0, 0,  3, 0, 0,       1, 0, 0,      0, 0, 0,  3,      5, 2, 0);
    add_vec(4,      0, 0, 0,  0, 0, 0,       1, 1, 2,      0, 0, 0,  4,      5, 2, 0);
    for (int f = 1; f <= 4; f++)
      add_vec(-2048, 0, 0, 0, f % 4, 0, 32767, 1, (f == 4) ? 1 : 0, -32768, 0, 0, 0, -32768, 5, 2, 0);
    for (int f = 1; f <= 4; f++)
      add_vec(2047, 0, 0, 0, f % 4, 0, -32768, 1, (f == 4) ? 1 : 0, 32767, 0, 0, 0, 32767, 5, 2, 0);
    for (int f = 1; f <= 4; f++)
      add_vec(-1, 0, 0, 0, f % 4, 0, 0, 1, (f == 4) ? 1 : 0, -1, 0, 0, 0, -1, 5, 2, 0);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_temp", out_temp, 0);
    check("rst_stale", stale_flag, 0);
    check("rst_drop", drop_count, 0);
    check("rst_err", err_count, 0);

    foreach (vecs[i]) begin
      strobe(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].t, vecs[i].frm, vecs[i].err, vecs[i].offx);
      @(negedge clock);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
      if (vecs[i].ov != 0) begin
        check($sformatf("v%0d_out_x", i), $signed(out_x), vecs[i].ex);
        check($sformatf("v%0d_out_y", i), $signed(out_y), vecs[i].ey);
        check($sformatf("v%0d_out_z", i), $signed(out_z), vecs[i].ez);
        check($sformatf("v%0d_out_temp", i), out_temp, vecs[i].et);
      end
      check($sformatf("v%0d_avg0_valid", i), ov0, vecs[i].acc);
      if (vecs[i].acc != 0)
        check($sformatf("v%0d_avg0_x", i), $signed(x0), vecs[i].e0x);
      check($sformatf("v%0d_drop", i), drop_count, vecs[i].drop);
      check($sformatf("v%0d_err", i), err_count, vecs[i].errc);
      check($sformatf("v%0d_stale", i), stale_flag, vecs[i].stale);
    end

    // Back-to-back strobes: pulses expected at loop cycles 5 and 9.
    npulse = 0; first_p = -1; second_p = -1; xa = 0; xb = 0;
    offset_x = '0; in_y = '0; in_z = '0; in_temp = '0; in_ack_error = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (out_valid) begin
        npulse++;
        if (npulse == 1) begin first_p = c; xa = $signed(out_x); end
        else if (npulse == 2) begin second_p = c; xb = $signed(out_x); end
      end
      if (c < 8) begin
        in_valid = 1'b1; in_x = 12'(10 + c); in_frm = 2'((c + 1) % 4);
      end else begin
        in_valid = 1'b0;
      end
    end
    check("b2b_pulses", npulse, 2);
    check("b2b_first_cycle", first_p, 5);
    check("b2b_second_cycle", second_p, 9);
    check("b2b_first_x", xa, 11);
    check("b2b_second_x", xb, 15);

    // clear with a simultaneous strobe after three accepted samples.
    strobe(20, 0, 0, 0, 1, 0, 0);
    strobe(21, 0, 0, 0, 2, 0, 0);
    strobe(22, 0, 0, 0, 3, 0, 0);
    @(negedge clock);
    clear = 1'b1; in_valid = 1'b1; in_x = 12'd999; in_frm = 2'd0;
    @(negedge clock);
    clear = 1'b0; in_valid = 1'b0;
    npulse = 0;
    repeat (4) begin
      @(negedge clock);
      if (out_valid) npulse++;
    end
    check("clr_no_output", npulse, 0);
    check("clr_hold_x", $signed(out_x), 15);
    check("clr_drop", drop_count, 0);
    check("clr_err", err_count, 0);
    strobe(40, 0, 0, 0, 0, 0, 0);
    strobe(44, 0, 0, 0, 1, 0, 0);
    strobe(48, 0, 0, 0, 2, 0, 0);
    strobe(52, 0, 0, 0, 3, 0, 0);
    @(negedge clock);
    check("clr_new_valid", out_valid, 1);
    check("clr_new_x", $signed(out_x), 46);

    // Reset mid-block discards the partial sum.
    strobe(1000, 0, 0, 0, 0, 0, 0);
    strobe(1000, 0, 0, 0, 1, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_valid", out_valid, 0);
    check("midrst_x", out_x, 0);
    strobe(4, 0, 0, 0, 0, 0, 0);
    strobe(8, 0, 0, 0, 1, 0, 0);
    strobe(12, 0, 0, 0, 2, 0, 0);
    strobe(16, 0, 0, 0, 3, 0, 0);
    @(negedge clock);
    check("midrst_new_valid", out_valid, 1);
    check("midrst_new_x", $signed(out_x), 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
